// File: rtl/param_inst_cache.sv
// param_inst_cache: parametrised read-only instruction cache between CPU fetch
// and block-wide instruction memory. 1- or 2-way (LRU), flush, and a two-state
// miss FSM (IDLE / MEM_READ) that refills one whole block per miss.
//
// Optional feature: define ICACHE_STATS_EN to add saturating hit_count and
// miss_count outputs.
//
// Ports:
//   clock, reset_n     rising-edge clock, async active-low reset
//   read, address      fetch request and byte address (bits [1:0] ignored)
//   flush              invalidate all lines
//   readdata           hit word (0 when not hitting)
//   busywait           CPU stall
//   mem_read           registered block read request
//   mem_address        block address (address[ADDR_W-1:OFF_W])
//   mem_readdata       refill block
//   mem_busywait       memory busy
//   hit_count/miss_count  (ICACHE_STATS_EN only) IDLE-cycle fetch counters

// One way of storage: valid, tag and data per set, with a lookup port for the
// current fetch and a fill port for the refill.
module param_inst_cache_way #(
  parameter int SETS   = 8,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 25,
  parameter int WPB    = 4,
  parameter int WSEL_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  input  logic [WSEL_W-1:0] rd_word,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [WPB*32-1:0] fill_data,
  input  logic              inval_all,
  output logic              line_vld,
  output logic              line_hit,
  output logic [31:0]       line_word
);
  logic [SETS-1:0]      valid;
  logic [TAG_W-1:0]     tag_mem  [SETS];
  logic [WPB-1:0][31:0] data_mem [SETS];
  logic [WPB-1:0][31:0] rd_blk;

  // Invalidation wins over a same-edge fill (flush racing a refill).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       valid <= '0;
    else if (inval_all) valid <= '0;
    else if (fill_en)   valid[fill_idx] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_data;
    end
  end

  assign rd_blk   = data_mem[rd_idx];
  assign line_vld = valid[rd_idx];
  assign line_hit = line_vld && (tag_mem[rd_idx] == rd_tag);

  if (WPB > 1) begin : g_wsel
    assign line_word = rd_blk[rd_word];
  end else begin : g_wsel1
    logic unused_word;
    assign unused_word = ^rd_word;
    assign line_word   = rd_blk[0];
  end
endmodule

module param_inst_cache #(
  parameter int ADDR_W          = 32,
  parameter int SETS            = 8,
  parameter int WAYS            = 2,
  parameter int WORDS_PER_BLOCK = 4,
  localparam int OFF_W  = $clog2(WORDS_PER_BLOCK) + 2,
  localparam int IDX_W  = $clog2(SETS),
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W,
  localparam int BLK_W  = 32 * WORDS_PER_BLOCK,
  localparam int WSEL_W = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    read,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    flush,
  output logic [31:0]             readdata,
  output logic                    busywait,
  output logic                    mem_read,
  output logic [ADDR_W-OFF_W-1:0] mem_address,
  input  logic [BLK_W-1:0]        mem_readdata,
  input  logic                    mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);
  if (WAYS < 1 || WAYS > 2 || SETS < 2 || (SETS & (SETS - 1)) != 0 ||
      WORDS_PER_BLOCK < 1 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_param
    $error("param_inst_cache: illegal WAYS/SETS/WORDS_PER_BLOCK");
  end

  typedef enum logic {IDLE = 1'b0, MEM_READ = 1'b1} state_t;
  state_t state;

  logic [IDX_W-1:0]  idx, lat_idx;
  logic [TAG_W-1:0]  tag, lat_tag;
  logic [WSEL_W-1:0] word_sel;
  logic              lat_way, victim, hit_way, flush_pending;
  logic              hit, fill_done, inval_all, hit_upd;
  logic [WAYS-1:0]   way_vld, way_hit, way_fill;
  logic [WAYS-1:0][31:0] way_word;
  logic [31:0]       hit_word;
  logic              unused_addr;

  assign idx         = address[OFF_W+IDX_W-1:OFF_W];
  assign tag         = address[ADDR_W-1:OFF_W+IDX_W];
  assign unused_addr = ^address[1:0];

  if (WORDS_PER_BLOCK > 1) begin : g_word
    assign word_sel = address[OFF_W-1:2];
  end else begin : g_word1
    assign word_sel = '0;
  end

  assign fill_done = (state == MEM_READ) && !mem_busywait;
  // A flush seen anywhere in the refill (including its last edge) kills the
  // freshly filled line along with everything else.
  assign inval_all = ((state == IDLE) && flush) ||
                     (fill_done && (flush_pending || flush));
  assign hit       = read && (|way_hit);
  assign hit_upd   = (state == IDLE) && !flush && hit;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_fill[w] = fill_done && (lat_way == 1'(w));
    param_inst_cache_way #(
      .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W),
      .WPB(WORDS_PER_BLOCK), .WSEL_W(WSEL_W)
    ) u_way (
      .clock     (clock),
      .reset_n   (reset_n),
      .rd_idx    (idx),
      .rd_tag    (tag),
      .rd_word   (word_sel),
      .fill_en   (way_fill[w]),
      .fill_idx  (lat_idx),
      .fill_tag  (lat_tag),
      .fill_data (mem_readdata),
      .inval_all (inval_all),
      .line_vld  (way_vld[w]),
      .line_hit  (way_hit[w]),
      .line_word (way_word[w])
    );
  end

  // LRU bit names the way to evict next in that set.
  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru;
    assign hit_way = way_hit[1];
    assign victim  = !way_vld[0] ? 1'b0 : (!way_vld[1] ? 1'b1 : lru[idx]);

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)       lru <= '0;
      else if (inval_all) lru <= '0;
      else if (hit_upd)   lru[idx] <= ~hit_way;
      else if (fill_done) lru[lat_idx] <= ~lat_way;
    end
  end else begin : g_dm
    logic unused_vld;
    assign unused_vld = ^way_vld;
    assign hit_way    = 1'b0;
    assign victim     = 1'b0;
  end

  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_word = way_word[w];
  end

  assign readdata = hit ? hit_word : 32'd0;
  assign busywait = (state != IDLE) || (read && !hit) || flush;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mem_read      <= 1'b0;
      mem_address   <= '0;
      lat_idx       <= '0;
      lat_tag       <= '0;
      lat_way       <= 1'b0;
      flush_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!flush && read && !hit) begin
            lat_idx     <= idx;
            lat_tag     <= tag;
            lat_way     <= victim;
            mem_read    <= 1'b1;
            mem_address <= address[ADDR_W-1:OFF_W];
            state       <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (flush) flush_pending <= 1'b1;
          if (!mem_busywait) begin
            mem_read      <= 1'b0;
            flush_pending <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if ((state == IDLE) && read && !flush) begin
      if (hit) begin
        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_param_inst_cache.sv
module tb_param_inst_cache;
  logic         clock = 1'b0;
  logic         reset_n, read, flush, mem_busywait;
  logic [31:0]  address;
  logic [31:0]  readdata;
  logic         busywait, mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int checks = 0;
  int errors = 0;

  param_inst_cache dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .read         (read),
    .address      (address),
    .flush        (flush),
    .readdata     (readdata),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Issue a miss, check the request, hold memory busy, refill, check the hit.
  task automatic miss_and_refill(input logic [31:0] a, input int busy,
                                 input logic [127:0] blk, input logic [27:0] exp_ma,
                                 input logic [31:0] exp_word);
    read = 1'b1; address = a; #1;
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL miss_stall @%h: busywait=%b want 1", a, busywait); end
    tick;
    checks++; if (mem_read !== 1'b1 || mem_address !== exp_ma) begin errors++;
      $display("FAIL miss_req @%h: mem_read=%b mem_address=%h want 1/%h", a, mem_read, mem_address, exp_ma); end
    repeat (busy) tick;
    mem_busywait = 1'b0; mem_readdata = blk;
    tick;
    mem_busywait = 1'b1;
    checks++; if (busywait !== 1'b0 || readdata !== exp_word) begin errors++;
      $display("FAIL refill_hit @%h: busywait=%b readdata=%h want 0/%h", a, busywait, readdata, exp_word); end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; read = 1'b0; flush = 1'b0; address = '0;
    mem_busywait = 1'b1; mem_readdata = '0;
    #12;
    checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL reset_busywait: got %b want 0", busywait); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
    checks++; if (mem_address !== 28'h0) begin errors++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
    checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h want 0", readdata); end
    read = 1'b1; #1;
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL reset_busy_eq_read: got %b want 1", busywait); end
    read = 1'b0;
    #1 reset_n = 1'b1;
    tick;
  endtask

  task automatic test_cold_miss;
    read = 1'b1; address = 32'h0; #1;
    checks++; if (busywait !== 1'b1 || mem_read !== 1'b0) begin errors++;
      $display("FAIL cold_stall: busywait=%b mem_read=%b want 1/0", busywait, mem_read); end
    tick;
    checks++; if (mem_read !== 1'b1 || mem_address !== 28'h0 || busywait !== 1'b1) begin errors++;
      $display("FAIL cold_req: mem_read=%b mem_address=%h busywait=%b want 1/0/1", mem_read, mem_address, busywait); end
    repeat (5) tick;
    checks++; if (mem_read !== 1'b1 || busywait !== 1'b1) begin errors++;
      $display("FAIL cold_hold: mem_read=%b busywait=%b want 1/1", mem_read, busywait); end
    mem_busywait = 1'b0; mem_readdata = {32'hD, 32'hC, 32'hB, 32'hA};
    tick;
    mem_busywait = 1'b1;
    checks++; if (busywait !== 1'b0 || readdata !== 32'hA || mem_read !== 1'b0) begin errors++;
      $display("FAIL cold_done: busywait=%b readdata=%h mem_read=%b want 0/0000000a/0", busywait, readdata, mem_read); end
  endtask

  task automatic test_hit_word;
    tick;
    address = 32'h8; #1;
    checks++; if (busywait !== 1'b0 || readdata !== 32'hC) begin errors++;
      $display("FAIL hit_word: busywait=%b readdata=%h want 0/0000000c", busywait, readdata); end
    tick;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL hit_no_mem_read: got %b want 0", mem_read); end
    read = 1'b0; #1;
`ifdef ICACHE_STATS_EN
    checks++; if (miss_count !== 32'd1 || hit_count !== 32'd2) begin errors++;
      $display("FAIL stats: miss=%0d hit=%0d want 1/2", miss_count, hit_count); end
`endif
  endtask

  task automatic test_lru;
    miss_and_refill(32'h080, 2, {32'h23, 32'h22, 32'h21, 32'h20}, 28'h08, 32'h20);
    address = 32'h0; #1;
    checks++; if (busywait !== 1'b0 || readdata !== 32'hA) begin errors++;
      $display("FAIL lru_hit0: busywait=%b readdata=%h want 0/0000000a", busywait, readdata); end
    tick;
    miss_and_refill(32'h100, 1, {32'h33, 32'h32, 32'h31, 32'h30}, 28'h10, 32'h30);
    address = 32'h0; #1;
    checks++; if (busywait !== 1'b0 || readdata !== 32'hA) begin errors++;
      $display("FAIL lru_keep0: busywait=%b readdata=%h want 0/0000000a", busywait, readdata); end
    tick;
    address = 32'h080; #1;
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL lru_evicted080: busywait=%b want 1", busywait); end
    tick;
    checks++; if (mem_read !== 1'b1 || mem_address !== 28'h08) begin errors++;
      $display("FAIL lru_refetch080: mem_read=%b mem_address=%h want 1/08", mem_read, mem_address); end
    mem_busywait = 1'b0; mem_readdata = {32'h23, 32'h22, 32'h21, 32'h20};
    tick;
    mem_busywait = 1'b1;
    read = 1'b0; #1;
  endtask

  task automatic test_flush_refill;
    read = 1'b1; address = 32'h0; #1;
    checks++; if (busywait !== 1'b0) begin errors++; $display("FAIL flush_pre0: busywait=%b want 0", busywait); end
    address = 32'h040; #1;
    tick;
    checks++; if (mem_read !== 1'b1 || mem_address !== 28'h04) begin errors++;
      $display("FAIL flush_req: mem_read=%b mem_address=%h want 1/04", mem_read, mem_address); end
    tick;
    flush = 1'b1; #1;
    tick;
    flush = 1'b0;
    tick;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL flush_hold: mem_read=%b want 1", mem_read); end
    mem_busywait = 1'b0; mem_readdata = {32'h43, 32'h42, 32'h41, 32'h40};
    tick;
    mem_busywait = 1'b1;
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL flush_done: mem_read=%b want 0", mem_read); end
    checks++; if (busywait !== 1'b1 || readdata !== 32'h0) begin errors++;
      $display("FAIL flush_040_miss: busywait=%b readdata=%h want 1/0", busywait, readdata); end
    address = 32'h0; #1;
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL flush_000_miss: busywait=%b want 1", busywait); end
    read = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_refill;
    read = 1'b1; address = 32'h0C0; #1;
    tick;
    checks++; if (mem_read !== 1'b1 || mem_address !== 28'h0C) begin errors++;
      $display("FAIL rst_req: mem_read=%b mem_address=%h want 1/0c", mem_read, mem_address); end
    #3 reset_n = 1'b0;
    #1;
    checks++; if (mem_read !== 1'b0 || mem_address !== 28'h0) begin errors++;
      $display("FAIL rst_drop: mem_read=%b mem_address=%h want 0/0", mem_read, mem_address); end
    checks++; if (busywait !== 1'b1 || readdata !== 32'h0) begin errors++;
      $display("FAIL rst_outputs: busywait=%b readdata=%h want 1/0", busywait, readdata); end
    #2 reset_n = 1'b1;
    #1;
    checks++; if (busywait !== 1'b1) begin errors++; $display("FAIL rst_after_busy: busywait=%b want 1", busywait); end
    tick;
    checks++; if (mem_read !== 1'b1 || mem_address !== 28'h0C) begin errors++;
      $display("FAIL rst_reissue: mem_read=%b mem_address=%h want 1/0c", mem_read, mem_address); end
    mem_busywait = 1'b0; mem_readdata = {32'h53, 32'h52, 32'h51, 32'h50};
    tick;
    mem_busywait = 1'b1;
    checks++; if (busywait !== 1'b0 || readdata !== 32'h50) begin errors++;
      $display("FAIL rst_refill: busywait=%b readdata=%h want 0/00000050", busywait, readdata); end
    read = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_cold_miss;
    test_hit_word;
    test_lru;
    test_flush_refill;
    test_reset_mid_refill;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
